// File: rtl/syzygy_adc_pkg.sv
// ---------------------------------------------------------------------------
// syzygy_adc_pkg
// Shared types and default sizing for the SYZYGY ADC capture controller.
//   state_e       : capture sequencer states (IDLE/SETTLE/CAPTURE/DONE)
//   *_W_DEF       : default sample, slot-count and settle-count widths
//   state_enc_on  : states in which the ADC encode clock must run
//   state_busy    : states reported to the host as busy
// ---------------------------------------------------------------------------
package syzygy_adc_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int CNT_W_DEF    = 20;
  localparam int SETTLE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Encode clock runs while the converter is settling or being sampled.
  function automatic logic state_enc_on(input state_e s);
    return (s == ST_SETTLE) || (s == ST_CAPTURE);
  endfunction

  // Any state other than IDLE counts as busy (DONE included).
  function automatic logic state_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/syzygy_adc_down_cnt.sv
// ---------------------------------------------------------------------------
// syzygy_adc_down_cnt
// Loadable down-counter with a zero flag. The sequencer loads N-1 for an
// N-cycle phase, so 'zero' marks the final cycle of that phase. Holds at 0.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   load     in   load load_val this cycle (wins over dec)
//   load_val in   W  value to load
//   dec      in   decrement by one when non-zero
//   zero     out  counter currently equals zero
// ---------------------------------------------------------------------------
module syzygy_adc_down_cnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/syzygy_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// syzygy_adc_capture_ctrl
// Sequences one SYZYGY ADC capture: enables the encode clock, waits out the
// converter settle time, then writes a fixed number of time-based sample slots
// into a downstream FIFO. Slots that hit fifo_full are dropped (overflow).
// Optional build macro: ADC_CAPTURE_TESTPAT_EN adds 'test_mode', which replaces
// the ADC data with a per-capture ramp (0,1,2,... one step per slot).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, abort      host control (start only honoured in IDLE; abort wins)
//   sample_count      slots per capture, latched on start
//   settle_cycles     encode-on cycles before the first slot, latched on start
//   test_mode         (ADC_CAPTURE_TESTPAT_EN only) ramp instead of ADC data
//   enc_en            encode clock gate enable
//   adc_data_in       ADC sample, valid every clk while enc_en
//   fifo_full         downstream FIFO full
//   fifo_wr_en/din    FIFO write strobe/data, one cycle after the slot
//   busy/done         status; done pulses once after a normal completion
//   overflow          sticky, at least one slot dropped this capture
//   samples_written   FIFO writes performed this capture
// ---------------------------------------------------------------------------
module syzygy_adc_capture_ctrl
  import syzygy_adc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    sample_count,
  input  logic [SETTLE_W-1:0] settle_cycles,
`ifdef ADC_CAPTURE_TESTPAT_EN
  input  logic                test_mode,
`endif
  output logic                enc_en,
  input  logic [DATA_W-1:0]   adc_data_in,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_din,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    samples_written
);

  localparam logic [CNT_W-1:0] SW_MAX = {CNT_W{1'b1}};

  state_e             state_r;
  state_e             state_nx_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   settle_ext_s;
  logic               cnt_load_s;
  logic [CNT_W-1:0]   cnt_load_val_s;
  logic               cnt_dec_s;
  logic               cnt_zero_s;
  logic               start_ok_s;
  logic               slot_s;
  logic [DATA_W-1:0]  din_src_s;

  assign settle_ext_s = CNT_W'(settle_cycles);

  // Shared phase counter: settle length first, then slot count.
  syzygy_adc_down_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and counter control. A slot is only taken when not aborting,
  // so an abort in CAPTURE produces no write for that cycle.
  always_comb begin
    state_nx_s     = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    cnt_dec_s      = 1'b0;
    start_ok_s     = 1'b0;
    slot_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          start_ok_s = 1'b1;
          cnt_load_s = 1'b1;
          if (sample_count == {CNT_W{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else if (settle_cycles == {SETTLE_W{1'b0}}) begin
            state_nx_s     = ST_CAPTURE;
            cnt_load_val_s = sample_count - CNT_W'(1);
          end else begin
            state_nx_s     = ST_SETTLE;
            cnt_load_val_s = settle_ext_s - CNT_W'(1);
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_zero_s) begin
          // count_r is non-zero here: a zero count never enters SETTLE.
          state_nx_s     = ST_CAPTURE;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = count_r - CNT_W'(1);
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          slot_s = 1'b1;
          if (cnt_zero_s) begin
            state_nx_s = ST_DONE;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latched slot count, needed again when SETTLE hands over to CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      count_r <= sample_count;
    end else begin
      count_r <= count_r;
    end
  end

`ifdef ADC_CAPTURE_TESTPAT_EN
  logic              test_mode_r;
  logic [DATA_W-1:0] ramp_r;

  // Test-pattern mode and ramp: ramp restarts each capture and advances on
  // every slot, including dropped ones, wrapping naturally at 2^DATA_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_mode_r <= 1'b0;
      ramp_r      <= {DATA_W{1'b0}};
    end else if (start_ok_s) begin
      test_mode_r <= test_mode;
      ramp_r      <= {DATA_W{1'b0}};
    end else if (slot_s) begin
      test_mode_r <= test_mode_r;
      ramp_r      <= ramp_r + DATA_W'(1);
    end else begin
      test_mode_r <= test_mode_r;
      ramp_r      <= ramp_r;
    end
  end

  assign din_src_s = test_mode_r ? ramp_r : adc_data_in;
`else
  assign din_src_s = adc_data_in;
`endif

  // Registered status and FIFO interface. done follows the DONE state by one
  // cycle, so it is seen after the final write has already been presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= {DATA_W{1'b0}};
    end else begin
      enc_en     <= state_enc_on(state_nx_s);
      busy       <= state_busy(state_nx_s);
      done       <= (state_r == ST_DONE) && !abort;
      fifo_wr_en <= slot_s && !fifo_full;
      if (slot_s) begin
        fifo_din <= din_src_s;
      end else begin
        fifo_din <= fifo_din;
      end
    end
  end

  // Sticky overflow, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (start_ok_s) begin
      overflow <= 1'b0;
    end else if (slot_s && fifo_full) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

  // Count of actual writes, cleared by an accepted start, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      samples_written <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      samples_written <= {CNT_W{1'b0}};
    end else if (slot_s && !fifo_full && (samples_written != SW_MAX)) begin
      samples_written <= samples_written + CNT_W'(1);
    end else begin
      samples_written <= samples_written;
    end
  end

endmodule

// File: tb/tb_syzygy_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_syzygy_adc_capture_ctrl
// Scoreboard bench: the stimulus task works out, from the capture timing
// (start accepted, settle_cycles encode-only cycles, then sample_count slots),
// which slots are written and with what data, and queues those words. A
// monitor thread pops the queue on every fifo_wr_en and compares.
// ---------------------------------------------------------------------------
module tb_syzygy_adc_capture_ctrl;

  localparam int DATA_W   = 12;
  localparam int CNT_W    = 20;
  localparam int SETTLE_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    sample_count;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                test_mode;
  logic                enc_en;
  logic [DATA_W-1:0]   adc_data_in;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [DATA_W-1:0]   fifo_din;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [CNT_W-1:0]    samples_written;

  always #5 clk = ~clk;

  syzygy_adc_capture_ctrl #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .SETTLE_W (SETTLE_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .sample_count    (sample_count),
    .settle_cycles   (settle_cycles),
`ifdef ADC_CAPTURE_TESTPAT_EN
    .test_mode       (test_mode),
`endif
    .enc_en          (enc_en),
    .adc_data_in     (adc_data_in),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_din        (fifo_din),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .samples_written (samples_written)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  int enc_total  = 0;
  int done_total = 0;
  int wr_total   = 0;
  int done_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts enc_en/done cycles and checks every FIFO write.
  task automatic monitor();
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (enc_en) enc_total++;
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
      if (fifo_wr_en) begin
        wr_total++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got data %0d, expected no write", fifo_din);
        end else begin
          e = exp_q.pop_front();
          check("fifo_din", fifo_din, e);
        end
      end
    end
  endtask

  // One capture. Called #1 after a rising edge. fmode: 0 never full,
  // 1 full in slots 3 and 4 (1-based), 2 random. abort_k: cycle after the
  // start edge (1-based) in which abort is pulsed, 0 for none.
  task automatic run_capture(input int count, input int settle, input int fmode,
                             input int abort_k, input bit mid_start, input bit tmode);
    int base_enc, base_done, base_wr, s_cyc, expwr, slot, total;
    bit expovf, aborted;
    logic [DATA_W-1:0] d, v;
    base_enc  = enc_total;
    base_done = done_total;
    base_wr   = wr_total;
    expwr     = 0;
    expovf    = 1'b0;
    aborted   = 1'b0;
    sample_count  = CNT_W'(count);
    settle_cycles = SETTLE_W'(settle);
    test_mode     = tmode;
    start         = 1'b1;
    abort         = 1'b0;
    fifo_full     = 1'b0;
    adc_data_in   = DATA_W'($urandom);
    @(posedge clk); #1;
    s_cyc = cyc;
    total = settle + count + 4;
    for (int k = 1; k <= total; k++) begin
      d = DATA_W'($urandom);
      adc_data_in = d;
      slot = (count > 0) ? (k - settle - 1) : -1;
      case (fmode)
        1:       fifo_full = (slot == 2) || (slot == 3);
        2:       fifo_full = ($urandom_range(3, 0) == 0);
        default: fifo_full = 1'b0;
      endcase
      abort = (k == abort_k);
      start = mid_start && (k == 2);
      // Latched values must not follow these inputs.
      sample_count  = CNT_W'($urandom_range(40, 0));
      settle_cycles = SETTLE_W'($urandom_range(9, 0));
      test_mode     = ~tmode;
      if (k == abort_k) aborted = 1'b1;
      if (k == 1) check("busy_active", busy, 1);
      if (!aborted && slot >= 0 && slot < count) begin
        v = tmode ? DATA_W'(slot) : d;
        if (fifo_full) begin
          expovf = 1'b1;
        end else begin
          exp_q.push_back(v);
          expwr++;
        end
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    abort     = 1'b0;
    fifo_full = 1'b0;
    check("done_pulses", done_total - base_done, aborted ? 0 : 1);
    if (!aborted) check("done_cycle", done_cyc - s_cyc, (count == 0) ? 1 : settle + count + 1);
    check("enc_cycles", enc_total - base_enc, aborted ? abort_k : ((count == 0) ? 0 : settle + count));
    check("writes", wr_total - base_wr, expwr);
    check("samples_written", samples_written, expwr);
    check("overflow", overflow, expovf);
    check("pending_writes", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("enc_idle", enc_en, 0);
    exp_q.delete();
  endtask

  initial begin
    int cnt, st, fm, ak;
    bit ms;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sample_count  = '0;
    settle_cycles = '0;
    test_mode     = 1'b0;
    adc_data_in   = '0;
    fifo_full     = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_en", enc_en, 0);
    check("rst_fifo_wr_en", fifo_wr_en, 0);
    check("rst_fifo_din", fifo_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_samples_written", samples_written, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_capture(4, 3, 0, 0, 1'b0, 1'b0);
    run_capture(0, 5, 0, 0, 1'b0, 1'b0);
    run_capture(8, 0, 1, 0, 1'b0, 1'b0);
    run_capture(6, 2, 0, 0, 1'b0, 1'b0);
    run_capture(10, 1, 0, 3, 1'b0, 1'b0);
    run_capture(10, 3, 2, 0, 1'b1, 1'b0);

    // start and abort together in IDLE: nothing may happen.
    start = 1'b1;
    abort = 1'b1;
    sample_count  = CNT_W'(5);
    settle_cycles = SETTLE_W'(0);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("start_abort_busy", busy, 0);
      check("start_abort_enc", enc_en, 0);
      @(posedge clk); #1;
    end

    for (int r = 0; r < 14; r++) begin
      cnt = $urandom_range(20, 0);
      st  = $urandom_range(6, 0);
      fm  = $urandom_range(2, 0);
      ak  = 0;
      if (cnt > 0 && $urandom_range(3, 0) == 0) ak = $urandom_range(st + cnt, 1);
      ms = (cnt > 0) && (st + cnt >= 2) && (ak == 0 || ak >= 2) && ($urandom_range(1, 0) == 1);
      run_capture(cnt, st, fm, ak, ms, 1'b0);
    end

`ifdef ADC_CAPTURE_TESTPAT_EN
    run_capture(5000, 2, 2, 0, 1'b0, 1'b1);
    run_capture(7, 1, 0, 0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
